axi_sram_slave: RTL and testbench
=================================

// Module: axi_sram_slave
// PURPOSE
//  AXI3 subordinate backed by an internal word array. It answers single-beat and INCR/FIXED bursts
//  from the SoC interconnect, e.g. the uart debug loader's 4'h2-ID stores/loads or CPU data accesses.
//  Read and write channels run independent FSMs against a 1R1W array; one outstanding transaction per
//  direction. Used as on-chip scratch RAM and as a debug-download target.
// PARAMETERS
//  DEPTH      1024           number of 32-bit words (power of 2, >=16)
//  BASE_ADDR  32'h1c00_0000  byte address of word 0 (DEPTH*4 aligned)
// PORTS
//  clk      in   1   clock; all logic on posedge
//  rst_n    in   1   reset, synchronous, active-low
//  arid     in   4   read ID             | awid     in   4  write ID
//  araddr   in   32  read byte address   | awaddr   in   32 write byte address
//  arlen    in   4   beats-1             | awlen    in   4  beats-1
//  arsize   in   3   ignored (4 B beats) | awsize   in   3  ignored (4 B beats)
//  arburst  in   2   00 FIXED, else INCR | awburst  in   2  00 FIXED, else INCR
//  arlock/arcache/arprot, awlock/awcache/awprot  in  2/4/3  ignored
//  arvalid  in 1 / arready out 1         | awvalid  in 1 / awready out 1
//  rid      out  4   echo of latched arid
//  rdata    out  32  read data (0 on DECERR)
//  rresp    out  2   00 OKAY, 11 DECERR
//  rlast    out  1   final beat
//  rvalid out 1 / rready in 1
//  wid      in   4   ignored; bid always equals the latched awid
//  wdata    in   32  write data
//  wstrb    in   4   byte enables; bit i -> wdata[8i+7:8i]
//  wlast    in   1   final write beat
//  wvalid in 1 / wready out 1
//  bid      out  4   latched awid
//  bresp    out  2   00 OKAY, 10 SLVERR (wlast/len mismatch), 11 DECERR (SLVERR wins)
//  bvalid out 1 / bready in 1
// BEHAVIOUR
//  Reset (sampled rst_n==0):
//   - FSMs go to IDLE; all ready/valid outputs 0; rid/bid/rresp/bresp/rdata/rlast 0.
//   - arready/awready assert the cycle after rst_n is first sampled 1.
//   - Array contents are not reset.
//   - Reset mid-burst abandons the burst with no response.
//  Word index = (addr-BASE_ADDR)>>2, truncated to log2(DEPTH) bits.
//   - In range iff BASE_ADDR <= addr < BASE_ADDR+4*DEPTH, checked per beat on the current address.
//   - addr[1:0] is ignored.
//  Beat address: FIXED holds the address; INCR adds 4. Wrap past 32'hffff_fffc goes out of range -> DECERR.
//  Read FSM R_IDLE -> R_DATA:
//   - R_IDLE: arready=1; on arvalid&arready latch id/addr/len/burst, load rdata/rresp for beat 0,
//     set beat cnt=0 -> R_DATA.
//   - R_DATA: arready=0, rvalid=1, rlast=(cnt==len). rdata/rresp stay stable while ~rready.
//   - On rvalid&rready: if rlast -> R_IDLE, else cnt++, advance addr, reload rdata next edge.
//   - First rvalid comes 1 cycle after the AR handshake. Back-to-back beats at 1/cycle under constant rready.
//   - Next arready comes 1 cycle after the last R handshake.
//  Write FSM W_IDLE -> W_DATA -> W_RESP:
//   - W_IDLE: awready=1; on handshake latch id/addr/len/burst, cnt=0, err=0.
//   - W_DATA: wready=1. Each wvalid&wready writes the strobed bytes if in range and cnt<=len;
//     otherwise no write (out of range sets DECERR, cnt>len sets SLVERR). SLVERR also if wlast
//     with cnt!=len. The burst ends only on wlast -> W_RESP.
//   - W_RESP: bvalid=1 with bid/bresp held until bready; then W_IDLE.
//  Same-edge read-load and write to one word: read returns the old data; the write lands.
//  Read and write FSMs never stall each other.
//  W beats presented before the AW handshake are not accepted: wready=0 outside W_DATA.
// TESTING
//  1 Single write awaddr=BASE+8, wdata=32'hdeadbeef, wstrb=f, then read same -> bresp 00, bid=2; rdata deadbeef, rresp 00, rlast 1.
//  2 Byte write wstrb=4'b0100, wdata=32'h00aa0000 over deadbeef -> read returns 32'hdeaabeef.
//  3 INCR read arlen=3 from BASE, rready toggling 1/0 -> 4 beats words 0..3, data stable while stalled, rlast only on beat 3.
//  4 Write to BASE+4*DEPTH -> bresp 11, array unchanged. Read there -> rdata 0, rresp 11.
//  5 awlen=1 with wlast on beat 0 -> bresp 10. Separately awlen=0 with 2 beats -> only beat 0 written, bresp 10.
//  6 Drop rst_n mid 4-beat read -> rvalid 0 next cycle; arready 1 the cycle after release; next read OKAY.

Source files
------------

// File: rtl/axi_sram_slave_if.sv
// rtl/axi_sram_slave_if.sv - AXI3 bus bundle between an interconnect master and the SRAM subordinate
interface axi_sram_slave_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI3 subordinate over a 1R1W word array, independent read and write FSMs
module axi_sram_slave #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h1c00_0000
) (
  input logic             clk,
  input logic             rst_n,
  axi_sram_slave_if.slave axi
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  typedef enum logic       {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  logic [31:0] mem_q [DEPTH];

  // Holds the address channels closed until the first cycle after reset release
  logic        alive_q;

  r_state_e    r_state_q, r_state_d;
  logic [3:0]  rid_q, rid_d, rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [31:0] raddr_q, raddr_d, rdata_q, rdata_d;
  logic        rovf_q, rovf_d, rfixed_q, rfixed_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rd_addr;
  logic        rd_ovf, rd_load, r_ok;
  logic [32:0] r_off, r_next;

  w_state_e    w_state_q, w_state_d;
  logic [3:0]  bid_q, bid_d, wlen_q, wlen_d;
  logic [4:0]  wcnt_q, wcnt_d;
  logic [31:0] waddr_q, waddr_d;
  logic        wovf_q, wovf_d, wfixed_q, wfixed_d, wslv_q, wslv_d, wdec_q, wdec_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        w_ok, w_in_len, mem_we;
  logic [32:0] w_off, w_next;

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    raddr_d   = raddr_q;
    rovf_d    = rovf_q;
    rfixed_d  = rfixed_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rd_load   = 1'b0;
    rd_addr   = raddr_q;
    rd_ovf    = rovf_q;
    r_next    = {1'b0, raddr_q} + (rfixed_q ? 33'd0 : 33'd4);
    case (r_state_q)
      R_IDLE: begin
        if (axi.arvalid && alive_q) begin
          rid_d     = axi.arid;
          rlen_d    = axi.arlen;
          rfixed_d  = (axi.arburst == 2'b00);
          rcnt_d    = 4'd0;
          rd_addr   = axi.araddr;
          rd_ovf    = 1'b0;
          rd_load   = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (axi.rready) begin
          if (rcnt_q == rlen_q) begin
            r_state_d = R_IDLE;
          end else begin
            rcnt_d  = rcnt_q + 4'd1;
            rd_addr = r_next[31:0];
            rd_ovf  = rovf_q | r_next[32];
            rd_load = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    // A borrow in r_off means the address lies below the window
    r_off = {1'b0, rd_addr} - {1'b0, BASE_ADDR};
    r_ok  = !rd_ovf && !r_off[32] && (r_off < SPAN);
    if (rd_load) begin
      raddr_d = rd_addr;
      rovf_d  = rd_ovf;
      rdata_d = r_ok ? mem_q[r_off[AW+1:2]] : 32'd0;
      rresp_d = r_ok ? 2'b00 : 2'b11;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    waddr_d   = waddr_q;
    wovf_d    = wovf_q;
    wfixed_d  = wfixed_q;
    wslv_d    = wslv_q;
    wdec_d    = wdec_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    w_next    = {1'b0, waddr_q} + (wfixed_q ? 33'd0 : 33'd4);
    w_off     = {1'b0, waddr_q} - {1'b0, BASE_ADDR};
    w_ok      = !wovf_q && !w_off[32] && (w_off < SPAN);
    w_in_len  = (wcnt_q <= {1'b0, wlen_q});
    case (w_state_q)
      W_IDLE: begin
        if (axi.awvalid && alive_q) begin
          bid_d     = axi.awid;
          wlen_d    = axi.awlen;
          wfixed_d  = (axi.awburst == 2'b00);
          waddr_d   = axi.awaddr;
          wovf_d    = 1'b0;
          wcnt_d    = 5'd0;
          wslv_d    = 1'b0;
          wdec_d    = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (axi.wvalid) begin
          mem_we = w_ok && w_in_len && rst_n;
          if (!w_ok) wdec_d = 1'b1;
          if (!w_in_len || (axi.wlast && (wcnt_q != {1'b0, wlen_q}))) wslv_d = 1'b1;
          waddr_d = w_next[31:0];
          wovf_d  = wovf_q | w_next[32];
          if (wcnt_q != 5'h1f) wcnt_d = wcnt_q + 5'd1;
          if (axi.wlast) begin
            bresp_d   = wslv_d ? 2'b10 : (wdec_d ? 2'b11 : 2'b00);
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (axi.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (axi.wstrb[i]) mem_q[w_off[AW+1:2]][8*i +: 8] <= axi.wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alive_q   <= 1'b0;
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      raddr_q   <= '0;
      rovf_q    <= 1'b0;
      rfixed_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      w_state_q <= W_IDLE;
      bid_q     <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      waddr_q   <= '0;
      wovf_q    <= 1'b0;
      wfixed_q  <= 1'b0;
      wslv_q    <= 1'b0;
      wdec_q    <= 1'b0;
      bresp_q   <= '0;
    end else begin
      alive_q   <= 1'b1;
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      raddr_q   <= raddr_d;
      rovf_q    <= rovf_d;
      rfixed_q  <= rfixed_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      w_state_q <= w_state_d;
      bid_q     <= bid_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      waddr_q   <= waddr_d;
      wovf_q    <= wovf_d;
      wfixed_q  <= wfixed_d;
      wslv_q    <= wslv_d;
      wdec_q    <= wdec_d;
      bresp_q   <= bresp_d;
    end
  end

  assign axi.arready = (r_state_q == R_IDLE) && alive_q;
  assign axi.rvalid  = (r_state_q == R_DATA);
  assign axi.rlast   = (r_state_q == R_DATA) && (rcnt_q == rlen_q);
  assign axi.rid     = rid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign axi.awready = (w_state_q == W_IDLE) && alive_q;
  assign axi.wready  = (w_state_q == W_DATA);
  assign axi.bvalid  = (w_state_q == W_RESP);
  assign axi.bid     = bid_q;
  assign axi.bresp   = bresp_q;

  logic unused_sigs;
  assign unused_sigs = ^{axi.arsize, axi.arlock, axi.arcache, axi.arprot, axi.arburst[1],
                         axi.awsize, axi.awlock, axi.awcache, axi.awprot, axi.awburst[1], axi.wid};
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - randomized self-checking bench for axi_sram_slave against a word-array model
module tb_axi_sram_slave;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h1c00_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_sram_slave_if axi();
  axi_sram_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (.clk(clk), .rst_n(rst_n), .axi(axi));

  int checks = 0;
  int passed = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wq_data[$];
  logic [3:0]  wq_strb[$];
  logic [31:0] got_data[$];
  logic [1:0]  got_resp[$];
  logic        got_last[$];
  logic [3:0]  got_rid[$];
  int          got_unstable, got_lat, got_end;
  logic [3:0]  got_bid;
  logic [1:0]  got_bresp;

  function automatic bit m_in(input longint a);
    return (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * DEPTH);
  endfunction

  function automatic longint m_beat(input logic [31:0] addr, input logic [1:0] burst, input int i);
    return longint'(addr) + ((burst == 2'b00) ? 0 : 4 * i);
  endfunction

  function automatic logic [31:0] m_rd(input longint a);
    return m_in(a) ? ref_mem[int'((a - longint'(BASE)) / 4)] : 32'd0;
  endfunction

  task automatic m_write(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                         output logic [1:0] exp);
    bit slv = 0;
    bit dec = 0;
    for (int i = 0; i < wq_data.size(); i++) begin
      longint a = m_beat(addr, burst, i);
      if (i > int'(len)) slv = 1;
      else if (!m_in(a)) dec = 1;
      else begin
        int idx = int'((a - longint'(BASE)) / 4);
        for (int b = 0; b < 4; b++)
          if (wq_strb[i][b]) ref_mem[idx][8*b +: 8] = wq_data[i][8*b +: 8];
      end
      if (i == wq_data.size() - 1 && i != int'(len)) slv = 1;
    end
    exp = slv ? 2'b10 : (dec ? 2'b11 : 2'b00);
  endtask

  task automatic init_inputs();
    axi.arid = 0; axi.araddr = 0; axi.arlen = 0; axi.arsize = 3'd2; axi.arburst = 2'b01;
    axi.arlock = 0; axi.arcache = 0; axi.arprot = 0; axi.arvalid = 0; axi.rready = 0;
    axi.awid = 0; axi.awaddr = 0; axi.awlen = 0; axi.awsize = 3'd2; axi.awburst = 2'b01;
    axi.awlock = 0; axi.awcache = 0; axi.awprot = 0; axi.awvalid = 0;
    axi.wid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0; axi.wvalid = 0; axi.bready = 0;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst);
    int n;
    got_bid = 'x;
    got_bresp = 'x;
    axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awburst = burst; axi.awvalid = 1;
    n = 0;
    while (axi.awready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (axi.awready !== 1'b1) begin axi.awvalid = 0; return; end
    @(posedge clk); #1;
    axi.awvalid = 0;
    for (int i = 0; i < wq_data.size(); i++) begin
      axi.wid = id; axi.wdata = wq_data[i]; axi.wstrb = wq_strb[i];
      axi.wlast = (i == wq_data.size() - 1); axi.wvalid = 1;
      n = 0;
      while (axi.wready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      if (axi.wready !== 1'b1) begin axi.wvalid = 0; axi.wlast = 0; return; end
      @(posedge clk); #1;
    end
    axi.wvalid = 0; axi.wlast = 0; axi.bready = 1;
    n = 0;
    while (axi.bvalid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (axi.bvalid === 1'b1) begin
      got_bid = axi.bid;
      got_bresp = axi.bresp;
      @(posedge clk); #1;
    end
    axi.bready = 0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input bit toggle);
    int n;
    bit held = 0;
    bit done = 0;
    logic [31:0] hd;
    logic [1:0] hr;
    logic hl;
    got_data.delete(); got_resp.delete(); got_last.delete(); got_rid.delete();
    got_unstable = 0; got_lat = -1; got_end = -1;
    axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arburst = burst; axi.arvalid = 1;
    n = 0;
    while (axi.arready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (axi.arready !== 1'b1) begin axi.arvalid = 0; return; end
    @(posedge clk); #1;
    axi.arvalid = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      axi.rready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (axi.rvalid === 1'b1) begin
        if (got_lat < 0) got_lat = c;
        if (held && (axi.rdata !== hd || axi.rresp !== hr || axi.rlast !== hl)) got_unstable++;
        hd = axi.rdata; hr = axi.rresp; hl = axi.rlast;
        held = !axi.rready;
        if (axi.rready) begin
          got_data.push_back(axi.rdata); got_resp.push_back(axi.rresp);
          got_last.push_back(axi.rlast); got_rid.push_back(axi.rid);
          if (axi.rlast) begin done = 1; got_end = c; end
        end
      end
      @(posedge clk); #1;
    end
    axi.rready = 0;
  endtask

  task automatic test_reset();
    init_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({axi.arready, axi.awready, axi.wready, axi.rvalid, axi.bvalid, axi.rlast} !== 6'b0)
      $display("FAIL reset_handshake: got %b want 000000",
               {axi.arready, axi.awready, axi.wready, axi.rvalid, axi.bvalid, axi.rlast});
    else passed++;
    checks++; if ({axi.rid, axi.bid, axi.rresp, axi.bresp, axi.rdata} !== 44'd0)
      $display("FAIL reset_fields: got %h want 0", {axi.rid, axi.bid, axi.rresp, axi.bresp, axi.rdata});
    else passed++;
    rst_n = 1;
    checks++; if (axi.arready !== 1'b0) $display("FAIL arready_before_sample: got %b want 0", axi.arready);
    else passed++;
    @(posedge clk); #1;
    checks++; if ({axi.arready, axi.awready} !== 2'b11)
      $display("FAIL ready_after_release: got %b want 11", {axi.arready, axi.awready});
    else passed++;
    checks++; if (axi.wready !== 1'b0) $display("FAIL wready_idle: got %b want 0", axi.wready);
    else passed++;
  endtask

  task automatic test_single();
    logic [1:0] exp;
    wq_data = '{32'hdeadbeef}; wq_strb = '{4'hf};
    do_write(4'h2, BASE + 8, 4'd0, 2'b01);
    m_write(BASE + 8, 4'd0, 2'b01, exp);
    checks++; if (got_bid !== 4'h2) $display("FAIL single_bid: got %h want 2", got_bid); else passed++;
    checks++; if (got_bresp !== 2'b00) $display("FAIL single_bresp: got %b want 00", got_bresp); else passed++;
    do_read(4'h5, BASE + 8, 4'd0, 2'b01, 0);
    checks++;
    if (got_data.size() != 1) $display("FAIL single_beats: got %0d want 1", got_data.size());
    else if ({got_data[0], got_resp[0], got_last[0], got_rid[0]} !== {32'hdeadbeef, 2'b00, 1'b1, 4'h5})
      $display("FAIL single_read: got %h/%b/%b/%h want deadbeef/00/1/5",
               got_data[0], got_resp[0], got_last[0], got_rid[0]);
    else passed++;
    checks++; if (got_lat !== 0) $display("FAIL single_rvalid_latency: got %0d want 0", got_lat); else passed++;
  endtask

  task automatic test_byte();
    logic [1:0] exp;
    wq_data = '{32'h00aa0000}; wq_strb = '{4'b0100};
    do_write(4'h2, BASE + 8, 4'd0, 2'b01);
    m_write(BASE + 8, 4'd0, 2'b01, exp);
    checks++; if (got_bresp !== 2'b00) $display("FAIL byte_bresp: got %b want 00", got_bresp); else passed++;
    do_read(4'h1, BASE + 8, 4'd0, 2'b01, 1);
    checks++;
    if (got_data.size() != 1) $display("FAIL byte_beats: got %0d want 1", got_data.size());
    else if (got_data[0] !== 32'hdeaabeef) $display("FAIL byte_read: got %h want deaabeef", got_data[0]);
    else passed++;
  endtask

  task automatic test_incr_read();
    logic [1:0] exp;
    wq_data.delete(); wq_strb.delete();
    for (int i = 0; i < 4; i++) begin wq_data.push_back($urandom); wq_strb.push_back(4'hf); end
    do_write(4'h3, BASE, 4'd3, 2'b01);
    m_write(BASE, 4'd3, 2'b01, exp);
    checks++; if (got_bresp !== 2'b00) $display("FAIL incr_wr_bresp: got %b want 00", got_bresp); else passed++;
    do_read(4'h7, BASE, 4'd3, 2'b01, 1);
    checks++; if (got_data.size() != 4) $display("FAIL incr_beats: got %0d want 4", got_data.size()); else passed++;
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if ({got_data[i], got_resp[i], got_last[i]} !== {ref_mem[i], 2'b00, 1'(i == 3)})
        $display("FAIL incr_beat%0d: got %h/%b/%b want %h/00/%b", i, got_data[i], got_resp[i],
                 got_last[i], ref_mem[i], i == 3);
      else passed++;
    end
    checks++; if (got_unstable != 0) $display("FAIL incr_stall_stable: got %0d changes want 0", got_unstable);
    else passed++;
  endtask

  task automatic test_decerr();
    logic [1:0] exp;
    wq_data = '{32'h5a5a1234}; wq_strb = '{4'hf};
    do_write(4'h4, BASE + 4 * (DEPTH - 1), 4'd0, 2'b01);
    m_write(BASE + 4 * (DEPTH - 1), 4'd0, 2'b01, exp);
    wq_data = '{$urandom}; wq_strb = '{4'hf};
    do_write(4'h4, BASE + 4 * DEPTH, 4'd0, 2'b01);
    m_write(BASE + 4 * DEPTH, 4'd0, 2'b01, exp);
    checks++; if (got_bresp !== 2'b11) $display("FAIL decerr_bresp: got %b want 11", got_bresp); else passed++;
    do_read(4'h0, BASE, 4'd0, 2'b01, 0);
    checks++;
    if (got_data.size() != 1) $display("FAIL decerr_alias_beats: got %0d want 1", got_data.size());
    else if (got_data[0] !== ref_mem[0]) $display("FAIL decerr_unchanged: got %h want %h", got_data[0], ref_mem[0]);
    else passed++;
    do_read(4'h0, BASE + 4 * DEPTH, 4'd0, 2'b01, 0);
    checks++;
    if (got_data.size() != 1) $display("FAIL decerr_rd_beats: got %0d want 1", got_data.size());
    else if ({got_data[0], got_resp[0]} !== {32'd0, 2'b11})
      $display("FAIL decerr_read: got %h/%b want 0/11", got_data[0], got_resp[0]);
    else passed++;
    do_read(4'h0, BASE - 4, 4'd0, 2'b01, 0);
    checks++;
    if (got_resp.size() != 1 || got_resp[0] !== 2'b11) $display("FAIL below_base: got %p want 11", got_resp);
    else passed++;
    do_read(4'h0, BASE + 4 * (DEPTH - 1), 4'd1, 2'b01, 0);
    checks++;
    if (got_data.size() != 2) $display("FAIL edge_beats: got %0d want 2", got_data.size());
    else if ({got_data[0], got_resp[0], got_data[1], got_resp[1]} !== {32'h5a5a1234, 2'b00, 32'd0, 2'b11})
      $display("FAIL edge_cross: got %h/%b %h/%b want 5a5a1234/00 0/11",
               got_data[0], got_resp[0], got_data[1], got_resp[1]);
    else passed++;
  endtask

  task automatic test_slverr();
    logic [1:0] exp;
    wq_data = '{32'h11112222, 32'h33334444, 32'h55556666}; wq_strb = '{4'hf, 4'hf, 4'hf};
    do_write(4'h6, BASE + 16, 4'd2, 2'b01);
    m_write(BASE + 16, 4'd2, 2'b01, exp);
    wq_data = '{32'ha0a0a0a0}; wq_strb = '{4'hf};
    do_write(4'h6, BASE + 16, 4'd1, 2'b01);
    m_write(BASE + 16, 4'd1, 2'b01, exp);
    checks++; if (got_bresp !== 2'b10) $display("FAIL short_wlast: got %b want 10", got_bresp); else passed++;
    wq_data = '{32'hb1b1b1b1, 32'hc2c2c2c2}; wq_strb = '{4'hf, 4'hf};
    do_write(4'h6, BASE + 20, 4'd0, 2'b01);
    m_write(BASE + 20, 4'd0, 2'b01, exp);
    checks++; if (got_bresp !== 2'b10) $display("FAIL long_burst: got %b want 10", got_bresp); else passed++;
    do_read(4'h2, BASE + 16, 4'd2, 2'b01, 0);
    checks++;
    if (got_data.size() != 3) $display("FAIL slverr_beats: got %0d want 3", got_data.size());
    else if ({got_data[0], got_data[1], got_data[2]} !== {32'ha0a0a0a0, 32'hb1b1b1b1, 32'h55556666})
      $display("FAIL slverr_contents: got %h %h %h want a0a0a0a0 b1b1b1b1 55556666",
               got_data[0], got_data[1], got_data[2]);
    else passed++;
  endtask

  task automatic test_random();
    logic [1:0] exp;
    for (int blk = 0; blk < DEPTH / 16; blk++) begin
      wq_data.delete(); wq_strb.delete();
      for (int i = 0; i < 16; i++) begin wq_data.push_back($urandom); wq_strb.push_back(4'hf); end
      do_write(4'h9, BASE + 64 * blk, 4'd15, 2'b01);
      m_write(BASE + 64 * blk, 4'd15, 2'b01, exp);
      checks++; if (got_bresp !== exp) $display("FAIL fill_bresp: got %b want %b", got_bresp, exp); else passed++;
    end
    for (int it = 0; it < 10; it++) begin
      logic [3:0]  len   = 4'($urandom_range(0, 7));
      logic [1:0]  burst = 2'($urandom_range(0, 2));
      logic [31:0] addr  = BASE + 4 * $urandom_range(DEPTH - 8, 0) + 32'($urandom_range(0, 3));
      logic [3:0]  id    = 4'($urandom);
      if (it % 3 == 2) addr = BASE + 4 * (DEPTH - 2);
      wq_data.delete(); wq_strb.delete();
      for (int i = 0; i <= int'(len); i++) begin wq_data.push_back($urandom); wq_strb.push_back(4'($urandom)); end
      do_write(id, addr, len, burst);
      m_write(addr, len, burst, exp);
      checks++;
      if ({got_bid, got_bresp} !== {id, exp})
        $display("FAIL rand_wr%0d: got %h/%b want %h/%b", it, got_bid, got_bresp, id, exp);
      else passed++;
      do_read(id, addr, len, burst, 1);
      checks++;
      if (got_data.size() != int'(len) + 1)
        $display("FAIL rand_rd%0d_beats: got %0d want %0d", it, got_data.size(), int'(len) + 1);
      else passed++;
      for (int i = 0; i < got_data.size(); i++) begin
        longint a = m_beat(addr, burst, i);
        checks++;
        if ({got_data[i], got_resp[i], got_last[i], got_rid[i]} !==
            {m_rd(a), m_in(a) ? 2'b00 : 2'b11, 1'(i == int'(len)), id})
          $display("FAIL rand_rd%0d_beat%0d: got %h/%b/%b/%h want %h/%b/%b/%h", it, i, got_data[i],
                   got_resp[i], got_last[i], got_rid[i], m_rd(a), m_in(a) ? 2'b00 : 2'b11, i == int'(len), id);
        else passed++;
      end
      checks++; if (got_unstable != 0) $display("FAIL rand_rd%0d_stable: got %0d", it, got_unstable); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp;
    logic [31:0] exp_rd [4];
    for (int i = 0; i < 4; i++) exp_rd[i] = ref_mem[40 + i];
    wq_data.delete(); wq_strb.delete();
    for (int i = 0; i < 4; i++) begin wq_data.push_back($urandom); wq_strb.push_back(4'hf); end
    fork
      do_write(4'ha, BASE + 40, 4'd3, 2'b01);
      do_read(4'hb, BASE + 160, 4'd3, 2'b01, 0);
    join
    m_write(BASE + 40, 4'd3, 2'b01, exp);
    checks++; if (got_bresp !== 2'b00) $display("FAIL b2b_bresp: got %b want 00", got_bresp); else passed++;
    checks++;
    if (got_data.size() != 4) $display("FAIL b2b_rd_beats: got %0d want 4", got_data.size());
    else if ({got_data[0], got_data[1], got_data[2], got_data[3]} !== {exp_rd[0], exp_rd[1], exp_rd[2], exp_rd[3]})
      $display("FAIL b2b_rd_data: got %h %h %h %h", got_data[0], got_data[1], got_data[2], got_data[3]);
    else passed++;
    do_read(4'hc, BASE + 40, 4'd7, 2'b01, 0);
    checks++; if ({got_lat, got_end} !== {32'sd0, 32'sd7})
      $display("FAIL burst_rate: got first %0d last %0d want 0 7", got_lat, got_end);
    else passed++;
    checks++;
    if (got_data.size() != 8 || got_data[1] !== ref_mem[11] || got_data[7] !== ref_mem[17])
      $display("FAIL b2b_wr_contents: got %p", got_data);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    axi.arid = 4'h1; axi.araddr = BASE; axi.arlen = 4'd3; axi.arburst = 2'b01; axi.arvalid = 1; axi.rready = 1;
    while (axi.arready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    axi.arvalid = 0;
    @(posedge clk); #1;
    checks++; if (axi.rvalid !== 1'b1) $display("FAIL mid_burst_active: got %b want 1", axi.rvalid); else passed++;
    rst_n = 0;
    @(posedge clk); #1;
    checks++; if ({axi.rvalid, axi.rlast} !== 2'b00)
      $display("FAIL rvalid_after_reset: got %b want 00", {axi.rvalid, axi.rlast});
    else passed++;
    axi.rready = 0;
    @(posedge clk); #1;
    rst_n = 1;
    checks++; if (axi.arready !== 1'b0) $display("FAIL arready_in_reset: got %b want 0", axi.arready); else passed++;
    @(posedge clk); #1;
    checks++; if (axi.arready !== 1'b1) $display("FAIL arready_after_reset: got %b want 1", axi.arready); else passed++;
    do_read(4'h8, BASE, 4'd3, 2'b01, 1);
    checks++;
    if (got_data.size() != 4) $display("FAIL post_reset_beats: got %0d want 4", got_data.size());
    else if ({got_resp[0], got_resp[3], got_data[0], got_data[3]} !== {2'b00, 2'b00, ref_mem[0], ref_mem[3]})
      $display("FAIL post_reset_read: got %b %b %h %h want 00 00 %h %h", got_resp[0], got_resp[3],
               got_data[0], got_data[3], ref_mem[0], ref_mem[3]);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_byte();
    test_incr_read();
    test_decerr();
    test_slverr();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
